// File: rtl/dwarf_leb128_decoder.sv
// LEB128 operand decoder for the DWARF line-table accelerator: byte FIFO in, 32-bit values out.
// Define LEB128_SIGNED_EN to honour signed_mode (SLEB128); otherwise every value decodes as ULEB128.
module dwarf_leb128_decoder #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    byte_in,
    input  logic                          byte_valid,
    output logic                          byte_ready,
    input  logic                          signed_mode,
    input  logic                          flush,
    output logic [31:0]                   value_out,
    output logic [2:0]                    value_bytes,
    output logic                          value_valid,
    input  logic                          value_ready,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
`ifdef LEB128_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t      state;
    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic [31:0] acc;
    logic [5:0]  shift;
    logic [2:0]  count;
    logic        sign_q;
    logic        valid_q;
    logic        ovf_q;

    logic        full, empty, push, pop, last;
    logic [7:0]  head;
    logic [31:0] base_acc, next_acc;
    logic [5:0]  base_shift, next_shift;
    logic [2:0]  base_count, next_count;
    logic        sign_cur, ovf_hit;

    assign fifo_level  = wr_ptr - rd_ptr;
    assign full        = (fifo_level == (AW + 1)'(FIFO_DEPTH));
    assign empty       = (wr_ptr == rd_ptr);
    assign byte_ready  = !full;
    assign push        = byte_valid && !full && !flush;
    // Accepting a held value frees the datapath, so the next byte can pop in the same cycle.
    assign pop         = !flush && !empty && (state == ACCUM || value_ready);
    assign head        = mem[rd_ptr[AW-1:0]];
    assign last        = !head[7];
    assign value_out   = acc;
    assign value_bytes = count;
    assign value_valid = valid_q;
    assign overflow    = ovf_q;

    always_comb begin
        base_acc   = (state == HOLD) ? 32'd0 : acc;
        base_shift = (state == HOLD) ? 6'd0 : shift;
        base_count = (state == HOLD) ? 3'd0 : count;
        sign_cur   = SIGNED_EN && ((base_count == 3'd0) ? signed_mode : sign_q);
        next_acc   = base_acc;
        ovf_hit    = 1'b0;
        // Only four payload bits fit at shift 28; the rest must be zero or a copy of the sign.
        if (base_shift <= 6'd21) begin
            next_acc = base_acc | ({25'd0, head[6:0]} << base_shift);
        end else if (base_shift == 6'd28) begin
            next_acc = base_acc | {head[3:0], 28'd0};
            ovf_hit  = sign_cur ? (head[6:4] != {3{head[3]}}) : (head[6:4] != 3'd0);
        end else begin
            ovf_hit = 1'b1;
        end
        next_shift = (base_shift >= 6'd35) ? 6'd35 : base_shift + 6'd7;
        next_count = (base_count == 3'd7) ? 3'd7 : base_count + 3'd1;
        if (last && sign_cur && head[6] && next_shift < 6'd32) begin
            next_acc = next_acc | (32'hFFFF_FFFF << next_shift[4:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= byte_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ACCUM;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            acc     <= '0;
            shift   <= '0;
            count   <= '0;
            sign_q  <= 1'b0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (flush) begin
            state   <= ACCUM;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            acc     <= '0;
            shift   <= '0;
            count   <= '0;
            sign_q  <= 1'b0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                acc     <= next_acc;
                shift   <= next_shift;
                count   <= next_count;
                sign_q  <= sign_cur;
                state   <= last ? HOLD : ACCUM;
                valid_q <= last;
                if (ovf_hit) begin
                    ovf_q <= 1'b1;
                end
            end else if (state == HOLD && value_ready) begin
                state   <= ACCUM;
                acc     <= '0;
                shift   <= '0;
                count   <= '0;
                valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dwarf_leb128_decoder.sv
// Directed bench for dwarf_leb128_decoder with hand-computed expected values.
// Signed expectations follow LEB128_SIGNED_EN, matching the build of the design.
module tb_dwarf_leb128_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        signed_mode;
    logic        flush;
    logic [31:0] value_out;
    logic [2:0]  value_bytes;
    logic        value_valid;
    logic        value_ready;
    logic        overflow;
    logic [2:0]  fifo_level;

    int checks_total  = 0;
    int checks_passed = 0;
    logic [7:0] stim [$];

    dwarf_leb128_decoder #(.FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .signed_mode(signed_mode), .flush(flush),
        .value_out(value_out), .value_bytes(value_bytes), .value_valid(value_valid),
        .value_ready(value_ready), .overflow(overflow), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks_total++;
        if (actual !== expected)
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        else
            checks_passed++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push the stim bytes back to back, wait for the value, check it, then accept it.
    task automatic applyStimulus(input string tag, input logic sm, input logic [31:0] exp_val,
                                 input logic [2:0] exp_bytes, input logic exp_ovf);
        int waited = 0;
        signed_mode = sm;
        foreach (stim[i]) begin
            byte_in    = stim[i];
            byte_valid = 1'b1;
            tick();
        end
        byte_valid = 1'b0;
        while (!value_valid && waited < 20) begin
            tick();
            waited++;
        end
        checkOutput({tag, "_valid"}, {31'd0, value_valid}, 32'd1);
        checkOutput({tag, "_value"}, value_out, exp_val);
        checkOutput({tag, "_bytes"}, {29'd0, value_bytes}, {29'd0, exp_bytes});
        checkOutput({tag, "_ovf"}, {31'd0, overflow}, {31'd0, exp_ovf});
        value_ready = 1'b1;
        tick();
        value_ready = 1'b0;
        signed_mode = 1'b0;
        stim.delete();
    endtask

    initial begin
        int accepted;
        logic [7:0] next_byte;
        rst = 1'b1; byte_in = 8'd0; byte_valid = 1'b0; signed_mode = 1'b0;
        flush = 1'b0; value_ready = 1'b0;
        #12;
        rst = 1'b0;
        tick();

        checkOutput("rst_byte_ready", {31'd0, byte_ready}, 32'd1);
        checkOutput("rst_valid", {31'd0, value_valid}, 32'd0);
        checkOutput("rst_value", value_out, 32'd0);
        checkOutput("rst_bytes", {29'd0, value_bytes}, 32'd0);
        checkOutput("rst_ovf", {31'd0, overflow}, 32'd0);
        checkOutput("rst_level", {29'd0, fifo_level}, 32'd0);

        stim.push_back(8'hE5); stim.push_back(8'h8E); stim.push_back(8'h26);
        applyStimulus("u3", 1'b0, 32'h0009_8765, 3'd3, 1'b0);

        stim.push_back(8'hC0); stim.push_back(8'hBB); stim.push_back(8'h78);
`ifdef LEB128_SIGNED_EN
        applyStimulus("s3", 1'b1, 32'hFFFE_1DC0, 3'd3, 1'b0);
`else
        applyStimulus("s3", 1'b1, 32'h001E_1DC0, 3'd3, 1'b0);
`endif

        stim.push_back(8'h7F);
`ifdef LEB128_SIGNED_EN
        applyStimulus("s1", 1'b1, 32'hFFFF_FFFF, 3'd1, 1'b0);
`else
        applyStimulus("s1", 1'b1, 32'h0000_007F, 3'd1, 1'b0);
`endif

        // Latency: push at edge N, valid only after edge N+1.
        byte_in = 8'h7F; byte_valid = 1'b1;
        tick();
        byte_valid = 1'b0;
        checkOutput("lat_n", {31'd0, value_valid}, 32'd0);
        tick();
        checkOutput("lat_n1", {31'd0, value_valid}, 32'd1);
        checkOutput("lat_value", value_out, 32'h0000_007F);
        value_ready = 1'b1;
        tick();
        value_ready = 1'b0;

        stim.push_back(8'hFF); stim.push_back(8'hFF); stim.push_back(8'hFF);
        stim.push_back(8'hFF); stim.push_back(8'h0F);
        applyStimulus("u5max", 1'b0, 32'hFFFF_FFFF, 3'd5, 1'b0);

        stim.push_back(8'hFF); stim.push_back(8'hFF); stim.push_back(8'hFF);
        stim.push_back(8'hFF); stim.push_back(8'h1F);
        applyStimulus("u5ovf", 1'b0, 32'hFFFF_FFFF, 3'd5, 1'b1);

        stim.push_back(8'h05);
        applyStimulus("sticky", 1'b0, 32'h0000_0005, 3'd1, 1'b1);

        // Backpressure: one value in HOLD plus four buffered bytes.
        accepted  = 0;
        next_byte = 8'd1;
        for (int i = 0; i < 10; i++) begin
            byte_in    = next_byte;
            byte_valid = 1'b1;
            if (byte_ready) begin
                accepted++;
                next_byte = next_byte + 8'd1;
            end
            tick();
        end
        byte_valid = 1'b0;
        checkOutput("bp_accepted", accepted, 32'd5);
        checkOutput("bp_byte_ready", {31'd0, byte_ready}, 32'd0);
        checkOutput("bp_level", {29'd0, fifo_level}, 32'd4);
        value_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            checkOutput($sformatf("drain%0d_valid", k), {31'd0, value_valid}, 32'd1);
            checkOutput($sformatf("drain%0d_value", k), value_out, k);
            tick();
        end
        value_ready = 1'b0;
        checkOutput("drain_empty", {31'd0, value_valid}, 32'd0);

        // Flush discards a partial value and clears sticky overflow.
        byte_in = 8'h80; byte_valid = 1'b1;
        tick(); tick();
        byte_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkOutput("flush_level", {29'd0, fifo_level}, 32'd0);
        checkOutput("flush_valid", {31'd0, value_valid}, 32'd0);
        checkOutput("flush_ovf", {31'd0, overflow}, 32'd0);
        stim.push_back(8'h05);
        applyStimulus("post_flush", 1'b0, 32'h0000_0005, 3'd1, 1'b0);

        // Asynchronous reset mid-value.
        byte_in = 8'h80; byte_valid = 1'b1;
        tick(); tick();
        byte_valid = 1'b0;
        rst = 1'b1;
        #2;
        checkOutput("arst_level", {29'd0, fifo_level}, 32'd0);
        checkOutput("arst_valid", {31'd0, value_valid}, 32'd0);
        checkOutput("arst_value", value_out, 32'd0);
        rst = 1'b0;
        stim.push_back(8'h05);
        applyStimulus("post_rst", 1'b0, 32'h0000_0005, 3'd1, 1'b0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
